// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache between the MIPS fetch stage
//   and a multi-cycle main-memory read port. A hit returns the instruction
//   combinationally. A miss raises missstall and refills the whole line with
//   a blocking burst of single-word reads.
//
// Ports
//   clk        in   1   clock
//   reset      in   1   synchronous active-high reset
//   pcF        in  32   fetch address (bits [1:0] ignored)
//   instrF     out 32   instruction to the fetch/decode register (0 = nop on miss)
//   missstall  out  1   fetch word not available; freezes fetch and decode
//   flush      in   1   invalidate all lines
//   mem_req    out  1   word read request
//   mem_addr   out 32   word-aligned request address
//   mem_ready  in   1   mem_rdata valid; accepts the current request
//   mem_rdata  in  32   returned word
// ---------------------------------------------------------------------------
module icache_direct #(
  parameter int SETS  = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        missstall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int OFFW = $clog2(WORDS) + 2;
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 32 - IDXW - OFFW;
  // The word counter needs at least one bit even for single-word lines.
  localparam int CNTW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DAW  = $clog2(SETS * WORDS);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WORDS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [SETS-1:0]   r_valid;
  logic [TAGW-1:0]   r_tag  [SETS];
  logic [31:0]       r_data [SETS*WORDS];
  logic [31:0]       r_missaddr;
  logic [CNTW-1:0]   r_cnt;
  logic              r_flush_pend;

  logic [TAGW-1:0]   w_tag;
  logic [IDXW-1:0]   w_idx;
  logic [CNTW-1:0]   w_word;
  logic [IDXW-1:0]   w_ms_idx;
  logic [DAW-1:0]    w_rd_addr;
  logic [DAW-1:0]    w_wr_addr;
  logic              w_hit;
  logic              w_fill_we;
  logic              w_fill_done;
  logic              w_unused_ok;

  // Lookup address fields of the current fetch address.
  assign w_tag  = pcF[31 -: TAGW];
  assign w_idx  = pcF[OFFW +: IDXW];
  assign w_word = (WORDS > 1) ? pcF[2 +: CNTW] : '0;

  // Line being refilled always comes from the latched miss address.
  assign w_ms_idx  = r_missaddr[OFFW +: IDXW];
  assign w_rd_addr = DAW'(32'(w_idx) * 32'(WORDS) + 32'(w_word));
  assign w_wr_addr = DAW'(32'(w_ms_idx) * 32'(WORDS) + 32'(r_cnt));

  // A flush forces the same-cycle lookup to miss.
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush;

  // Byte-offset bits of the PC play no part in an aligned word fetch.
  assign w_unused_ok = &{1'b0, pcF[1:0]};

  // Next-state, fetch-side outputs and memory request generation.
  always_comb begin
    w_next_state = r_state;
    instrF       = 32'h0000_0000;
    missstall    = 1'b1;
    mem_req      = 1'b0;
    mem_addr     = 32'h0000_0000;
    w_fill_we    = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          instrF    = r_data[w_rd_addr];
          missstall = 1'b0;
        end else begin
          w_next_state = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = r_missaddr + (32'(r_cnt) << 2);
        if (mem_ready) begin
          w_fill_we = 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_fill_done  = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_fill_done = 1'b0;
          end
        end else begin
          w_fill_we = 1'b0;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Control state: FSM, valid bits, word counter, pending flush, miss address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_missaddr   <= 32'h0000_0000;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          r_cnt        <= '0;
          r_flush_pend <= 1'b0;
          if (flush) begin
            r_valid <= '0;
          end
          if (!w_hit) begin
            r_missaddr <= {pcF[31:OFFW], {OFFW{1'b0}}};
          end
        end
        REFILL: begin
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
          if (mem_ready) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_fill_done) begin
            // A flush seen at any point of the burst leaves every line invalid.
            if (r_flush_pend || flush) begin
              r_valid <= '0;
            end else begin
              r_valid[w_ms_idx] <= 1'b1;
            end
            r_flush_pend <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Tag array write at the end of a burst; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_fill_done && !reset) begin
      r_tag[w_ms_idx] <= r_missaddr[31 -: TAGW];
    end
  end

  // Data array write, one word per accepted memory response.
  always_ff @(posedge clk) begin
    if (w_fill_we && !reset) begin
      r_data[w_wr_addr] <= mem_rdata;
    end
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined MIPS fetch stage (pcF/instrF) and a multi-cycle main-memory port.
- Hits return the instruction combinationally in the same cycle.
- Misses raise missstall so the hazard unit freezes fetch and decode while a whole line is refilled by a blocking burst of single-word requests.

Parameters:
- SETS, 16, number of lines; power of 2, at least 2.
- WORDS, 4, 32-bit words per line; power of 2, at least 1.
- Derived (not overridable): OFFW = log2(WORDS)+2; IDXW = log2(SETS); TAGW = 32-IDXW-OFFW.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pcF  in  32  fetch address; bits [1:0] ignored
- instrF  out  32  instruction to the fetch-to-decode register
- missstall  out  1  high while the fetch word is not available; feeds the stallF/stallD hazard logic
- flush  in  1  invalidate all lines
- mem_req  out  1  word read request
- mem_addr  out  32  word-aligned request address
- mem_ready  in  1  mem_rdata valid; accepts the current request
- mem_rdata  in  32  returned word

Behaviour:
- Reset is synchronous on the clk rising edge while reset=1.
  - state=IDLE, all valid bits 0, word counter 0, pending-flush 0, mem_req 0.
  - Tag and data arrays are not reset.
- Address split: tag=pcF[31:32-TAGW], index=pcF[OFFW+IDXW-1:OFFW], word=pcF[OFFW-1:2].
- IDLE state:
  - hit = valid[index] and tag match.
  - On a hit: instrF=data[index][word] and missstall=0, both combinational.
  - On a miss: instrF=32'h0 (nop), missstall=1 combinationally, and missaddr={pcF[31:OFFW], OFFW zeros} is latched. Next state is REFILL with the counter cleared.
- REFILL state:
  - missstall=1, instrF=32'h0, mem_req=1, mem_addr=missaddr+(cnt<<2).
  - mem_addr and mem_req are held stable until mem_ready.
  - On mem_ready: write mem_rdata into data[line][cnt], then cnt++.
  - When cnt=WORDS-1 and mem_ready: write tag, set valid for the line (unless a flush is pending), and return to IDLE.
- Timing and isolation:
  - pcF changes during REFILL are ignored, since the latched missaddr is used.
  - After returning to IDLE, the lookup uses the current pcF. With the PC held, the re-lookup is a hit on the cycle after the last mem_ready.
  - Miss penalty with zero wait states: WORDS+1 cycles of missstall=1 (1 detect cycle plus WORDS refill cycles). Each wait state adds 1 cycle.
- mem_ready outside REFILL is ignored. mem_req is 0 in IDLE.
- Flush:
  - In IDLE, flush=1 clears all valid bits at the clock edge and forces the same-cycle lookup to miss.
  - Flush during REFILL sets pending-flush. The burst completes, but the refilled line is not marked valid.
  - On return to IDLE, all valid bits clear and pending-flush clears.
- Reset during REFILL aborts immediately: mem_req=0 in the next cycle, and the partially filled line stays invalid.
- Memory accesses are reads only, exactly one per word. A line is never fetched twice for one miss.

Test Plan:
- Cold miss, SETS=16, WORDS=4, zero wait states: pcF=0x00400008 after reset.
  - missstall=1 for 5 cycles.
  - mem_addr sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
  - Then a hit with instrF equal to the third word returned.
- Line reuse: after the cold fill, pcF steps 0x00400000 to 0x0040000C, one per cycle.
  - missstall=0 every cycle and mem_req=0.
  - instrF matches the four stored words.
- Conflict eviction: fill 0x00400000, then fetch 0x00400100 (same index, different tag), then 0x00400000 again.
  - Both later fetches miss and refill, each with 4 requests.
- Wait states: mem_ready asserted only every 3rd cycle.
  - mem_addr and mem_req stay constant between readies.
  - missstall lasts 1+4*3=13 cycles.
- Flush: flush pulsed in the second REFILL cycle.
  - The burst still completes all 4 words.
  - The next lookup at the same pcF misses again.
  - Flush in IDLE after a hit makes that cycle's missstall=1.
- Reset mid-refill: reset asserted after 2 of 4 words.
  - mem_req=0 in the following cycle.
  - The next fetch of that line misses and refetches from word 0.
